moore_seq_ctrl: RTL

- Sequencer for a single-bit Moore detector (din/dout style FSM with its own synchronous reset).
- Accepts a parallel word over a valid/ready handshake, clears the detector, and shifts the word into it LSB-first, one bit per clock.
- Counts the clock cycles in which the detector output is high, then returns that count on a result valid/ready handshake.
- Sits between a word-level producer/consumer and the bit-serial detector, so one detector instance serves word traffic.

---
 rtl/moore_pkg.sv | 27 ++
 rtl/moore_piso.sv | 42 ++++
 rtl/moore_seq_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/moore_pkg.sv
// ---------------------------------------------------------------------------
// moore_pkg : shared state encoding and sizing helpers for moore_seq_ctrl
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package moore_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Smallest hit-counter width that can hold a full word of hits.
  function automatic int min_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = min_cnt_w(DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/moore_piso.sv
// ---------------------------------------------------------------------------
// moore_piso : WIDTH-bit parallel-in/serial-out shifter, LSB first
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module moore_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic             last_o
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
      idx_q   <= '0;
    end else if (shift_i) begin
      shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
      idx_q   <= idx_q + IDX_W'(1);
    end
  end

  assign bit_o  = shreg_q[0];
  assign last_o = (idx_q == IDX_W'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/moore_seq_ctrl.sv
// ---------------------------------------------------------------------------
// moore_seq_ctrl : feeds words bit-serially into a Moore detector, counts hits
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module moore_seq_ctrl
  import moore_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             det_rst_o,
  output logic             det_din_o,
  input  logic             det_dout_i,
  output logic             res_valid_o,
  output logic [CNT_W-1:0] res_count_o,
  input  logic             res_ready_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             samp_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] res_q;
  logic             load;
  logic             shift;
  logic             piso_bit;
  logic             piso_last;

  moore_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (in_data_i),
    .shift_i (shift),
    .bit_o   (piso_bit),
    .last_o  (piso_last)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    det_rst_o   = rst;
    det_din_o   = 1'b0;
    res_valid_o = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          load    = 1'b1;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        det_rst_o = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        det_din_o = piso_bit;
        shift     = 1'b1;
        if (piso_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // samp_q marks the cycle after a SHIFT, when det_dout reflects that bit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (samp_q && det_dout_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      samp_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= (state_q == ST_SHIFT);
      cnt_q   <= cnt_d;
      // The last sample lands in DRAIN; publish it as REPORT begins.
      if (state_q == ST_DRAIN) res_q <= cnt_d;
    end
  end

  assign res_count_o = res_q;

endmodule

`default_nettype wire
